// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
package rr_grant_arbiter_pkg;

    localparam int GRANT_W     = 8;
    localparam int PTR_W       = 3;
    localparam int CNT_W       = 8;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from the top bit back to bit 0.
module rr_pick
    import rr_grant_arbiter_pkg::*;
(
    input  logic [GRANT_W-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [GRANT_W-1:0] winner,
    output logic [PTR_W-1:0]   index,
    output logic               valid
);

    logic [PTR_W-1:0] pos;

    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        pos    = '0;
        // pos is PTR_W wide, so the add wraps 7 -> 0 on its own
        for (int i = 0; i < GRANT_W; i++) begin
            pos = ptr + PTR_W'(i);
            if (!valid && req[pos]) begin
                valid = 1'b1;
                index = pos;
            end
        end
        if (valid) begin
            winner[index] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with hold timeout; every output is a flop so
// the downstream encoder never sees a combinational path from req/ack.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [GRANT_W-1:0] req_in,
    input  logic               ack_in,
    output logic [GRANT_W-1:0] grant_out,
    output logic               enable_out,
    output logic               timeout_out,
    output logic               busy_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state, state_nx;
    logic [GRANT_W-1:0] grant, grant_nx;
    logic [PTR_W-1:0]   idx, idx_nx;
    logic [PTR_W-1:0]   ptr, ptr_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               timeout, timeout_nx;
    logic               enable, enable_nx;
    logic               busy, busy_nx;
    logic               done_early;
    logic               hit_limit;

    logic [GRANT_W-1:0] pick_winner;
    logic [PTR_W-1:0]   pick_index;
    logic               pick_valid;

    rr_pick u_pick (
        .req    (req_in),
        .ptr    (ptr),
        .winner (pick_winner),
        .index  (pick_index),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            grant   <= '0;
            idx     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
            enable  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            idx     <= idx_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
            timeout <= timeout_nx;
            enable  <= enable_nx;
            busy    <= busy_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        idx_nx     = idx;
        ptr_nx     = ptr;
        cnt_nx     = cnt;
        timeout_nx = 1'b0;
        done_early = 1'b0;
        hit_limit  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nx = ST_GRANT;
                    grant_nx = pick_winner;
                    idx_nx   = pick_index;
                    cnt_nx   = '0;
                end
            end
            ST_GRANT: begin
                done_early = ack_in || !req_in[idx];
                hit_limit  = (cnt == LAST);
                if (done_early || hit_limit) begin
                    state_nx   = ST_RELEASE;
                    grant_nx   = '0;
                    ptr_nx     = idx + 1'b1;
                    cnt_nx     = '0;
                    // ack or drop wins over a coincident timeout
                    timeout_nx = !done_early;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
                cnt_nx   = '0;
            end
        endcase
        enable_nx = (grant_nx != '0);
        busy_nx   = (state_nx != ST_IDLE);
    end

    assign grant_out   = grant;
    assign enable_out  = enable;
    assign timeout_out = timeout;
    assign busy_out    = busy;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (TIMEOUT_CYCLES = 4).
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req_in;
    logic       ack_in;
    logic [7:0] grant_out;
    logic       enable_out;
    logic       timeout_out;
    logic       busy_out;

    int passed = 0;
    int total  = 0;
    bit mon_on = 1'b0;

    rr_grant_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .ack_in      (ack_in),
        .grant_out   (grant_out),
        .enable_out  (enable_out),
        .timeout_out (timeout_out),
        .busy_out    (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("onehot0", 32'($onehot0(grant_out)), 32'd1);
            chk("enable_eq", 32'(enable_out), 32'(grant_out != 8'h00));
        end
    end

    initial begin
        logic [7:0] e;
        reset  = 1'b1;
        req_in = 8'h00;
        ack_in = 1'b0;
        #2;
        chk("rst_grant", 32'(grant_out), 32'h00);
        chk("rst_enable", 32'(enable_out), 32'h0);
        chk("rst_busy", 32'(busy_out), 32'h0);
        chk("rst_timeout", 32'(timeout_out), 32'h0);
        mon_on = 1'b1;
        #10;
        reset = 1'b0;

        // 8'h24: bit 2 first, then bit 5 once ptr moves to 3
        req_in = 8'h24;
        tick();
        chk("g24_first", 32'(grant_out), 32'h04);
        chk("g24_enable", 32'(enable_out), 32'h1);
        chk("g24_busy", 32'(busy_out), 32'h1);
        tick();
        chk("g24_hold", 32'(grant_out), 32'h04);
        ack_in = 1'b1;
        tick();
        chk("g24_rel", 32'(grant_out), 32'h00);
        chk("g24_rel_busy", 32'(busy_out), 32'h1);
        chk("g24_rel_to", 32'(timeout_out), 32'h0);
        ack_in = 1'b0;
        tick();
        chk("g24_idle_busy", 32'(busy_out), 32'h0);
        tick();
        chk("g24_second", 32'(grant_out), 32'h20);
        req_in = 8'h00;
        tick();
        chk("drop_rel_g", 32'(grant_out), 32'h00);
        chk("drop_rel_to", 32'(timeout_out), 32'h0);
        tick();

        // async reset pulse between edges returns ptr to 0
        reset = 1'b1;
        #1;
        reset = 1'b0;

        // all-ones with ack: rotate 01..80 then wrap to 01
        req_in = 8'hFF;
        ack_in = 1'b1;
        for (int k = 0; k < 9; k++) begin
            e = 8'h01 << (k % 8);
            tick();
            chk("rot_grant", 32'(grant_out), 32'(e));
            tick();
            chk("rot_rel", 32'(grant_out), 32'h00);
            tick();
            chk("rot_idle", 32'(grant_out), 32'h00);
            chk("rot_idle_busy", 32'(busy_out), 32'h0);
        end

        // timeout: 4 grant cycles then one-cycle pulse
        req_in = 8'h10;
        ack_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("to_hold", 32'(grant_out), 32'h10);
            chk("to_hold_pulse", 32'(timeout_out), 32'h0);
        end
        tick();
        chk("to_rel_g", 32'(grant_out), 32'h00);
        chk("to_pulse", 32'(timeout_out), 32'h1);
        req_in = 8'h00;
        tick();
        chk("to_pulse_end", 32'(timeout_out), 32'h0);
        chk("to_idle_busy", 32'(busy_out), 32'h0);

        // ack coinciding with the limit suppresses the pulse
        req_in = 8'h10;
        tick();
        tick();
        tick();
        tick();
        chk("prec_hold", 32'(grant_out), 32'h10);
        ack_in = 1'b1;
        tick();
        chk("prec_rel_g", 32'(grant_out), 32'h00);
        chk("prec_no_pulse", 32'(timeout_out), 32'h0);
        ack_in = 1'b0;
        req_in = 8'h00;
        tick();

        // drop without ack: release, no pulse, ptr = 1
        req_in = 8'h01;
        tick();
        chk("drop_grant", 32'(grant_out), 32'h01);
        req_in = 8'h00;
        tick();
        chk("drop_g", 32'(grant_out), 32'h00);
        chk("drop_busy", 32'(busy_out), 32'h1);
        chk("drop_to", 32'(timeout_out), 32'h0);
        tick();
        req_in = 8'h03;
        tick();
        chk("ptr1_scan", 32'(grant_out), 32'h02);

        // reset mid-GRANT, between edges
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_g", 32'(grant_out), 32'h00);
        chk("mid_rst_en", 32'(enable_out), 32'h0);
        chk("mid_rst_busy", 32'(busy_out), 32'h0);
        chk("mid_rst_to", 32'(timeout_out), 32'h0);
        reset = 1'b0;
        req_in = 8'h81;
        tick();
        chk("post_rst_scan0", 32'(grant_out), 32'h01);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        req_in = 8'h00;
        tick();
        req_in = 8'h80;
        tick();
        chk("post_rst_80", 32'(grant_out), 32'h80);
        chk("post_rst_80_en", 32'(enable_out), 32'h1);

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
